logic_pipe: RTL

LOGIC_PIPE -- requirements
Module: logic_pipe

---
 rtl/logic_pkg.sv | 20 ++
 rtl/logic_stage.sv | 39 +++
 rtl/logic_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logic_pkg
//  Purpose  : Shared opcode encodings for the logic_pipe ALU decode.
//  Revision : 1.0  initial release
// ============================================================================
package logic_pkg;

  localparam int OP_W = 2;

  // Bitwise operation selected by the 2-bit opcode
  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

endpackage
`default_nettype wire

// File: rtl/logic_stage.sv
`default_nettype none
// ============================================================================
//  Module   : logic_stage
//  Purpose  : One pipeline slot: a valid flag plus a WIDTH-bit data register,
//             both updated only when the slot advances.
//  Revision : 1.0  initial release
// ============================================================================
module logic_stage import logic_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid flag follows the upstream valid whenever this slot advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= in_valid;
    end
  end

  // Data loads only when a valid item actually moves in; bubbles leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (advance && in_valid) begin
      data <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_pipe
//  Purpose  : DEPTH-stage valid/ready pipeline computing AND/OR/XOR/NAND of two
//             WIDTH-bit operands; the operation is evaluated in stage 0 and
//             the result is carried unchanged through the remaining stages.
//  Revision : 1.0  initial release
// ============================================================================
module logic_pipe import logic_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [1:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    case (op)
      OP_AND:  logic_op = a & b;
      OP_OR:   logic_op = a | b;
      OP_XOR:  logic_op = a ^ b;
      default: logic_op = ~(a & b);
    endcase
  endfunction

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] stage_in_valid;
  logic [WIDTH-1:0] data          [DEPTH];
  logic [WIDTH-1:0] stage_in_data [DEPTH];
  logic [WIDTH-1:0] op_result;

  assign op_result = logic_op(data1, data2, opcode);

  // Advance chain: a slot moves when it is empty or its successor moves;
  // the last slot moves when the consumer is ready. Evaluated tail-first.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !valid[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !valid[k] || adv[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in_valid[k] = in_valid;
      assign stage_in_data[k]  = op_result;
    end else begin : g_tail
      assign stage_in_valid[k] = valid[k-1];
      assign stage_in_data[k]  = data[k-1];
    end

    logic_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (adv[k]),
      .in_valid (stage_in_valid[k]),
      .in_data  (stage_in_data[k]),
      .valid    (valid[k]),
      .data     (data[k])
    );
  end

  // Outputs are forced to zero whenever the last slot is empty
  assign in_ready  = adv[0];
  assign out_valid = valid[DEPTH-1];
  assign result    = out_valid ? data[DEPTH-1] : '0;
  assign zero      = out_valid && (data[DEPTH-1] == '0);

endmodule
`default_nettype wire
